// File: rtl/pushbutton_conditioner.sv
// Conditions four raw pushbuttons for the processor: two-flop synchronisers,
// per-button press/release debounce FSMs, edge strobes and optional sticky flags.
module pushbutton_conditioner #(
    parameter int DEBOUNCE_CYCLES = 16,
    parameter int CNT_WIDTH       = 5,
    parameter bit STICKY          = 1'b0
) (
    input  logic       clock,
    input  logic       reset,
    input  logic [3:0] raw_buttons,
    input  logic [3:0] clear,
    output logic [3:0] buttons,
    output logic [3:0] level,
    output logic [3:0] press_pulse,
    output logic [3:0] release_pulse
);

    typedef enum logic [1:0] {
        ST_RELEASED      = 2'd0,
        ST_PRESS_CHECK   = 2'd1,
        ST_PRESSED       = 2'd2,
        ST_RELEASE_CHECK = 2'd3
    } state_e;

    localparam logic [CNT_WIDTH-1:0] CNT_ZERO = {CNT_WIDTH{1'b0}};
    localparam logic [CNT_WIDTH-1:0] CNT_ONE  = CNT_WIDTH'(1);
    localparam logic [CNT_WIDTH-1:0] CNT_LAST = CNT_WIDTH'(DEBOUNCE_CYCLES - 1);

    logic [3:0]           sync1_q;
    logic [3:0]           sync2_q;
    state_e               state_q [4];
    state_e               state_d [4];
    logic [CNT_WIDTH-1:0] cnt_q   [4];
    logic [CNT_WIDTH-1:0] cnt_d   [4];
    logic [3:0]           level_q;
    logic [3:0]           level_d;
    logic [3:0]           press_q;
    logic [3:0]           press_d;
    logic [3:0]           release_q;
    logic [3:0]           release_d;
    logic [3:0]           flag_q;
    logic [3:0]           flag_d;
    logic [3:0]           buttons_q;
    logic [3:0]           buttons_d;

    // State register: synchronisers, FSMs, counters and all registered outputs
    always_ff @(posedge clock or negedge reset) begin
        if (!reset) begin
            sync1_q   <= 4'b0000;
            sync2_q   <= 4'b0000;
            level_q   <= 4'b0000;
            press_q   <= 4'b0000;
            release_q <= 4'b0000;
            flag_q    <= 4'b0000;
            buttons_q <= 4'b0000;
            for (int i = 0; i < 4; i++) begin
                state_q[i] <= ST_RELEASED;
                cnt_q[i]   <= CNT_ZERO;
            end
        end else begin
            sync1_q   <= raw_buttons;
            sync2_q   <= sync1_q;
            level_q   <= level_d;
            press_q   <= press_d;
            release_q <= release_d;
            flag_q    <= flag_d;
            buttons_q <= buttons_d;
            for (int i = 0; i < 4; i++) begin
                state_q[i] <= state_d[i];
                cnt_q[i]   <= cnt_d[i];
            end
        end
    end

    // Next-state logic: each check restarts on any disagreeing sample
    always_comb begin
        for (int i = 0; i < 4; i++) begin
            state_d[i] = state_q[i];
            cnt_d[i]   = cnt_q[i];
            case (state_q[i])
                ST_RELEASED: begin
                    if (sync2_q[i]) begin
                        state_d[i] = ST_PRESS_CHECK;
                        cnt_d[i]   = CNT_ONE;
                    end else begin
                        cnt_d[i]   = CNT_ZERO;
                    end
                end
                ST_PRESS_CHECK: begin
                    if (!sync2_q[i]) begin
                        state_d[i] = ST_RELEASED;
                        cnt_d[i]   = CNT_ZERO;
                    end else if (cnt_q[i] == CNT_LAST) begin
                        state_d[i] = ST_PRESSED;
                        cnt_d[i]   = CNT_ZERO;
                    end else begin
                        cnt_d[i]   = cnt_q[i] + CNT_ONE;
                    end
                end
                ST_PRESSED: begin
                    if (!sync2_q[i]) begin
                        state_d[i] = ST_RELEASE_CHECK;
                        cnt_d[i]   = CNT_ONE;
                    end else begin
                        cnt_d[i]   = CNT_ZERO;
                    end
                end
                ST_RELEASE_CHECK: begin
                    if (sync2_q[i]) begin
                        state_d[i] = ST_PRESSED;
                        cnt_d[i]   = CNT_ZERO;
                    end else if (cnt_q[i] == CNT_LAST) begin
                        state_d[i] = ST_RELEASED;
                        cnt_d[i]   = CNT_ZERO;
                    end else begin
                        cnt_d[i]   = cnt_q[i] + CNT_ONE;
                    end
                end
                default: begin
                    state_d[i] = ST_RELEASED;
                    cnt_d[i]   = CNT_ZERO;
                end
            endcase
        end
    end

    // Output logic: strobes mark accepted transitions; set beats clear on sticky flags
    always_comb begin
        level_d   = 4'b0000;
        press_d   = 4'b0000;
        release_d = 4'b0000;
        flag_d    = 4'b0000;
        for (int i = 0; i < 4; i++) begin
            level_d[i]   = (state_d[i] == ST_PRESSED) || (state_d[i] == ST_RELEASE_CHECK);
            press_d[i]   = (state_d[i] == ST_PRESSED) && (state_q[i] == ST_PRESS_CHECK);
            release_d[i] = (state_d[i] == ST_RELEASED) && (state_q[i] == ST_RELEASE_CHECK);
        end
        if (STICKY) begin
            flag_d    = press_q | (flag_q & ~clear);
            buttons_d = flag_d;
        end else begin
            flag_d    = 4'b0000;
            buttons_d = level_d;
        end
    end

    assign buttons       = buttons_q;
    assign level         = level_q;
    assign press_pulse   = press_q;
    assign release_pulse = release_q;

endmodule
